// File: rtl/sm_mac_seq.sv
// -----------------------------------------------------------------------------
// sm_mac_seq
//   Sequencer for the sign-magnitude multiply / sign-restore datapath feeding a
//   subarray MAC. Accepts a vector of sign-magnitude operand pairs over a
//   valid/ready stream. Each pair is multiplied (magnitude product, then
//   two's-complement sign restore) into a stage-1 product register. The products
//   are summed into a two's-complement accumulator. The dot product is presented
//   on a valid/ready result port, together with a sticky signed-overflow flag.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, cfg_len    begin a vector of cfg_len pairs (sampled only in IDLE)
//   busy              high whenever the sequencer is not idle
//   in_valid/in_ready operand-pair handshake, a_in / b_in sign-magnitude
//   out_valid/ready   result handshake, acc_out / ovf held until accepted
// -----------------------------------------------------------------------------
module sm_mac_seq #(
  parameter int MAG_W = 7,
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAG_W:0]     a_in,
  input  logic [MAG_W:0]     b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   acc_out,
  output logic               ovf
);

  localparam int PROD_W = 2 * MAG_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Signed product of two sign-magnitude operands. A zero magnitude always
  // yields +0, so a -0 operand never produces a negative-zero pattern.
  function automatic logic [PROD_W-1:0] sm_product(input logic [MAG_W:0] a,
                                                   input logic [MAG_W:0] b);
    logic             s;
    logic [PROD_W-1:0] m;
    s = a[MAG_W] ^ b[MAG_W];
    m = PROD_W'(a[MAG_W-1:0]) * PROD_W'(b[MAG_W-1:0]);
    if (m == {PROD_W{1'b0}}) begin
      sm_product = {PROD_W{1'b0}};
    end else if (s) begin
      sm_product = -m;
    end else begin
      sm_product = m;
    end
  endfunction

  state_t              state_r;
  state_t              state_next_s;
  logic [LEN_W-1:0]    len_r;
  logic [LEN_W-1:0]    cnt_r;
  logic [PROD_W-1:0]   p_r;
  logic                p_v_r;
  logic [ACC_W-1:0]    acc_r;
  logic                start_go_s;
  logic                accept_s;
  logic                last_s;
  logic [ACC_W-1:0]    p_ext_s;
  logic [ACC_W-1:0]    sum_s;
  logic                sum_ovf_s;

  assign start_go_s = (state_r == IDLE) && start;
  assign accept_s   = (state_r == RUN) && in_ready && in_valid;
  assign last_s     = (cnt_r == (len_r - LEN_W'(1)));
  assign p_ext_s    = ACC_W'($signed(p_r));
  assign sum_s      = acc_r + p_ext_s;
  // Overflow: both addends share a sign but the wrapped sum does not.
  assign sum_ovf_s  = (acc_r[ACC_W-1] == p_ext_s[ACC_W-1]) &&
                      (sum_s[ACC_W-1] != acc_r[ACC_W-1]);

  // Next-state logic of the vector sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (cfg_len != {LEN_W{1'b0}}) begin
            state_next_s = RUN;
          end else begin
            state_next_s = DONE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s && last_s) begin
          state_next_s = FLUSH;
        end else begin
          state_next_s = RUN;
        end
      end
      FLUSH: begin
        state_next_s = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered handshake/status outputs, derived from the upcoming state.
  // out_valid rises one cycle after entering DONE so that it lines up with
  // the registered acc_out copy of the final accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      busy      <= (state_next_s != IDLE);
      in_ready  <= (state_next_s == RUN);
      out_valid <= (state_r == DONE) && (state_next_s == DONE);
    end
  end

  // Vector length latch and accepted-pair counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r <= {LEN_W{1'b0}};
      cnt_r <= {LEN_W{1'b0}};
    end else if (start_go_s) begin
      len_r <= cfg_len;
      cnt_r <= {LEN_W{1'b0}};
    end else if (accept_s) begin
      cnt_r <= cnt_r + LEN_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Stage 1: product register, valid for exactly one cycle per accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r   <= {PROD_W{1'b0}};
      p_v_r <= 1'b0;
    end else if (accept_s) begin
      p_r   <= sm_product(a_in, b_in);
      p_v_r <= 1'b1;
    end else begin
      p_v_r <= 1'b0;
    end
  end

  // Stage 2: wrapping accumulator with sticky overflow, cleared on start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= {ACC_W{1'b0}};
      ovf   <= 1'b0;
    end else if (start_go_s) begin
      acc_r <= {ACC_W{1'b0}};
      ovf   <= 1'b0;
    end else if (p_v_r) begin
      acc_r <= sum_s;
      ovf   <= ovf | sum_ovf_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  // Registered copy of the accumulator; stable in DONE since nothing adds there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_out <= {ACC_W{1'b0}};
    end else begin
      acc_out <= acc_r;
    end
  end

endmodule

// File: tb/tb_sm_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_sm_mac_seq
//   Directed testbench for sm_mac_seq. Two instances share all stimulus: the
//   default 24-bit accumulator and a 16-bit accumulator variant used for the
//   overflow case. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_sm_mac_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_len;
  logic        in_valid;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        out_ready;

  logic        busy, in_ready, out_valid, ovf;
  logic [23:0] acc_out;
  logic        busy16, in_ready16, out_valid16, ovf16;
  logic [15:0] acc_out16;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  sm_mac_seq #(.MAG_W(7), .ACC_W(24), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .ovf(ovf)
  );

  sm_mac_seq #(.MAG_W(7), .ACC_W(16), .LEN_W(8)) dut16 (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy16),
    .in_valid(in_valid), .in_ready(in_ready16), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid16), .out_ready(out_ready), .acc_out(acc_out16), .ovf(ovf16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] len);
    start   = 1'b1;
    cfg_len = len;
    tick();
    start   = 1'b0;
  endtask

  // Present one pair and hold it until it is accepted (bounded wait).
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_len = 8'd0; in_valid = 1'b0;
    a_in = 8'd0; b_in = 8'd0; out_ready = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_acc_out", 32'(acc_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    #2 rst = 1'b0;
    tick();

    // 1: products 12, -10, -7 -> -5; out_valid exactly 2 clk after last accept
    do_start(8'd3);
    check("t1_busy", 32'(busy), 32'd1);
    send(8'h03, 8'h04);
    send(8'h85, 8'h02);
    send(8'h07, 8'h81);
    check("t1_ready_low", 32'(in_ready), 32'd0);
    tick();
    check("t1_lat1_valid", 32'(out_valid), 32'd0);
    tick();
    check("t1_lat2_valid", 32'(out_valid), 32'd1);
    check("t1_acc", 32'(acc_out), 32'h00FF_FFFB);
    check("t1_ovf", 32'(ovf), 32'd0);
    handshake();

    // 2: zero magnitudes, including -0, give +0
    do_start(8'd2);
    send(8'h80, 8'h85);
    send(8'h00, 8'h7F);
    wait_out();
    check("t2_acc", 32'(acc_out), 32'd0);
    check("t2_ovf", 32'(ovf), 32'd0);
    handshake();

    // 3: zero-length vector goes straight to DONE
    do_start(8'd0);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_in_ready_a", 32'(in_ready), 32'd0);
    tick();
    check("t3_out_valid", 32'(out_valid), 32'd1);
    check("t3_in_ready_b", 32'(in_ready), 32'd0);
    check("t3_acc", 32'(acc_out), 32'd0);
    handshake();

    // 4: input gaps, output back-pressure, start ignored in DONE
    // 1*1 + (-2*3) + 10*10 + (-4*-4) = 111
    do_start(8'd4);
    send(8'h01, 8'h01);
    tick();
    send(8'h82, 8'h03);
    tick(); tick(); tick();
    send(8'h0A, 8'h0A);
    tick(); tick();
    send(8'h84, 8'h84);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      start   = i[0];
      cfg_len = 8'd1;
      tick();
      check("t4_hold_acc", 32'(acc_out), 32'd111);
      check("t4_hold_valid", 32'(out_valid), 32'd1);
    end
    start = 1'b0;
    handshake();
    tick();
    check("t4_stay_idle", 32'(busy), 32'd0);

    // 5: 3 x (127*127) = 48387: overflows a 16-bit accumulator only
    do_start(8'd3);
    send(8'h7F, 8'h7F);
    send(8'h7F, 8'h7F);
    send(8'h7F, 8'h7F);
    wait_out();
    check("t5_acc16", 32'(acc_out16), 32'h0000_BD03);
    check("t5_ovf16", 32'(ovf16), 32'd1);
    check("t5_acc24", 32'(acc_out), 32'h0000_BD03);
    check("t5_ovf24", 32'(ovf), 32'd0);
    handshake();

    // ovf must clear on the next start
    do_start(8'd1);
    send(8'h01, 8'h01);
    wait_out();
    check("t5_ovf16_clr", 32'(ovf16), 32'd0);
    check("t5_acc16_next", 32'(acc_out16), 32'd1);
    handshake();

    // 6: asynchronous reset in the middle of a vector
    do_start(8'd4);
    send(8'h05, 8'h05);
    send(8'h03, 8'h03);
    check("t6_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_acc", 32'(acc_out), 32'd0);
    check("t6_ovf", 32'(ovf), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    do_start(8'd1);
    send(8'h02, 8'h03);
    wait_out();
    check("t6_acc_after", 32'(acc_out), 32'd6);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
